// File: rtl/lstm_pkg.sv
// Shared types and helpers for the LSTM cell: gate/FSM enums, weight
// address map, and fixed-point activation / narrowing functions.
// Build option: define LSTM_SAT_EN to saturate every narrowing to WIDTH;
// without it narrowing wraps (two's complement).
package lstm_pkg;

    typedef enum logic [1:0] {I, F, G, O} gate_t;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        HMAC,
        ACT,
        CELL,
        OUTC,
        DONE
    } state_t;

`ifdef LSTM_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Weight address map: input weights, then recurrent weights, then biases
    function automatic int wx_addr(input int g, input int j, input int n_in);
        return g * n_in + j;
    endfunction

    function automatic int wh_addr(input int g, input int n_in);
        return 4 * n_in + g;
    endfunction

    function automatic int b_addr(input int g, input int n_in);
        return 4 * n_in + 4 + g;
    endfunction

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        longint r;
        r = v;
        if (v < lo) r = lo;
        else if (v > hi) r = hi;
        return r;
    endfunction

    // Returns v clamped to the signed range of 'width' bits when sat is set;
    // otherwise v unchanged, so the caller's truncation wraps.
    function automatic longint narrow(input longint v, input int width, input bit sat);
        longint hi;
        longint lo;
        longint r;
        hi = (longint'(1) <<< (width - 1)) - longint'(1);
        lo = -(longint'(1) <<< (width - 1));
        r  = v;
        if (sat) r = clamp(v, lo, hi);
        return r;
    endfunction

    // clamp(s/4 + 0.5, 0, 1)
    function automatic longint hard_sigmoid(input longint s, input int frac);
        return clamp((s >>> 2) + (longint'(1) <<< (frac - 1)), 0, longint'(1) <<< frac);
    endfunction

    // clamp(s, -1, 1)
    function automatic longint hard_tanh(input longint s, input int frac);
        return clamp(s, -(longint'(1) <<< frac), longint'(1) <<< frac);
    endfunction

endpackage

// File: rtl/lstm_gate_mac.sv
// Per-gate pre-activation datapath: accumulates x*wx over the input beats,
// then folds in the recurrent term and bias and narrows to WIDTH.
module lstm_gate_mac
    import lstm_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 34
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    first_beat,
    input  logic                    acc_beat,
    input  logic                    hmac_en,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] wx,
    input  logic signed [WIDTH-1:0] hs,
    input  logic signed [WIDTH-1:0] wh,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] s
);

    logic signed [ACC_W-1:0] acc_reg;
    longint                  prod;
    longint                  mac;

    // Input product and accumulator-plus-recurrent sum
    always_comb begin
        prod = longint'(x) * longint'(wx);
        mac  = longint'(acc_reg) + longint'(hs) * longint'(wh);
    end

    // First beat restarts the sum; HMAC captures the narrowed pre-activation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            s       <= '0;
        end else begin
            if (first_beat) begin
                acc_reg <= ACC_W'(prod);
            end else if (acc_beat) begin
                acc_reg <= ACC_W'(longint'(acc_reg) + prod);
            end
            if (hmac_en) begin
                s <= WIDTH'(narrow((mac >>> FRAC) + longint'(b), WIDTH, SAT_EN));
            end
        end
    end

endmodule

// File: rtl/lstm_seq.sv
// Sequential LSTM cell: streams an N_IN-element input vector, keeps h and C
// across time steps, and emits one hidden output and cell state per step.
// Build option: LSTM_SAT_EN selects saturating narrowing (see lstm_pkg).
module lstm_seq
    import lstm_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int FRAC   = 8,
    parameter  int N_IN   = 4,
    localparam int ADDR_W = $clog2(4 * N_IN + 8),
    localparam int ACC_W  = 2 * WIDTH + $clog2(N_IN + 2)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic signed [WIDTH-1:0] wr_data,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic                    x_valid,
    input  logic                    x_last,
    input  logic                    seq_start,
    output logic                    x_ready,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] C_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int DEPTH = 1 << IDX_W;

    state_t                  state_reg;
    logic [IDX_W-1:0]        cnt_reg;
    logic [IDX_W-1:0]        wx_idx;
    logic                    x_ready_reg;
    logic                    out_valid_reg;
    logic                    outc_phase_reg;
    logic signed [WIDTH-1:0] hs_reg;
    logic signed [WIDTH-1:0] cs_reg;
    logic signed [WIDTH-1:0] cn_reg;
    logic signed [WIDTH-1:0] t_reg;
    logic signed [WIDTH-1:0] y_reg;
    logic signed [WIDTH-1:0] c_reg;
    logic signed [WIDTH-1:0] act_reg [4];
    logic signed [WIDTH-1:0] s_vec   [4];

    logic beat;
    logic first_beat;
    logic acc_beat;
    logic hmac_en;

    assign beat       = x_valid && x_ready_reg;
    assign first_beat = beat && (state_reg == IDLE);
    assign acc_beat   = beat && (state_reg == ACCUM);
    assign hmac_en    = (state_reg == HMAC);
    // The first beat always uses column 0; later beats follow the counter
    assign wx_idx     = (state_reg == IDLE) ? '0 : cnt_reg;

    assign x_ready    = x_ready_reg;
    assign out_valid  = out_valid_reg;
    assign y_out      = y_reg;
    assign C_out      = c_reg;
    assign busy       = (state_reg != IDLE);

    // One weight bank and MAC per gate; all four gates run in lock-step
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_gate
            localparam int WH_A = wh_addr(gi, N_IN);
            localparam int B_A  = b_addr(gi, N_IN);

            logic signed [WIDTH-1:0] wx_row [DEPTH];
            logic signed [WIDTH-1:0] wh_w;
            logic signed [WIDTH-1:0] b_w;

            // Weight writes land only while idle; unmatched addresses fall through
            always_ff @(posedge clk) begin
                if (wr_en && (state_reg == IDLE)) begin
                    for (int j = 0; j < N_IN; j++) begin
                        if (wr_addr == ADDR_W'(wx_addr(gi, j, N_IN))) wx_row[j] <= wr_data;
                    end
                    if (wr_addr == ADDR_W'(WH_A)) wh_w <= wr_data;
                    if (wr_addr == ADDR_W'(B_A))  b_w  <= wr_data;
                end
            end

            lstm_gate_mac #(
                .WIDTH (WIDTH),
                .FRAC  (FRAC),
                .ACC_W (ACC_W)
            ) u_mac (
                .clk        (clk),
                .rst_n      (rst_n),
                .first_beat (first_beat),
                .acc_beat   (acc_beat),
                .hmac_en    (hmac_en),
                .x          (x_in),
                .wx         (wx_row[wx_idx]),
                .hs         (hs_reg),
                .wh         (wh_w),
                .b          (b_w),
                .s          (s_vec[gi])
            );
        end
    endgenerate

    // Step sequencer with the activation / cell / output pipeline stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            x_ready_reg    <= 1'b0;
            out_valid_reg  <= 1'b0;
            outc_phase_reg <= 1'b0;
            hs_reg         <= '0;
            cs_reg         <= '0;
            cn_reg         <= '0;
            t_reg          <= '0;
            y_reg          <= '0;
            c_reg          <= '0;
            for (int k = 0; k < 4; k++) act_reg[k] <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    x_ready_reg <= 1'b1;
                    if (beat) begin
                        cnt_reg <= IDX_W'(1);
                        // A new sequence starts from zero recurrent state
                        if (seq_start) begin
                            hs_reg <= '0;
                            cs_reg <= '0;
                        end
                        if (x_last || (N_IN == 1)) begin
                            state_reg   <= HMAC;
                            x_ready_reg <= 1'b0;
                        end else begin
                            state_reg <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        cnt_reg <= cnt_reg + IDX_W'(1);
                        // Stop at x_last or once the vector is full
                        if (x_last || (int'(cnt_reg) + 1 == N_IN)) begin
                            state_reg   <= HMAC;
                            x_ready_reg <= 1'b0;
                        end
                    end
                end
                HMAC: begin
                    state_reg <= ACT;
                end
                ACT: begin
                    for (int k = 0; k < 4; k++) begin
                        if (k == int'(G))
                            act_reg[k] <= WIDTH'(hard_tanh(longint'(s_vec[k]), FRAC));
                        else
                            act_reg[k] <= WIDTH'(hard_sigmoid(longint'(s_vec[k]), FRAC));
                    end
                    state_reg <= CELL;
                end
                CELL: begin
                    cn_reg <= WIDTH'(narrow(
                        (longint'(act_reg[F]) * longint'(cs_reg) +
                         longint'(act_reg[I]) * longint'(act_reg[G])) >>> FRAC,
                        WIDTH, SAT_EN));
                    outc_phase_reg <= 1'b0;
                    state_reg      <= OUTC;
                end
                OUTC: begin
                    // Two beats: squash the cell state, then scale by the output gate
                    if (!outc_phase_reg) begin
                        t_reg          <= WIDTH'(hard_tanh(longint'(cn_reg), FRAC));
                        outc_phase_reg <= 1'b1;
                    end else begin
                        y_reg <= WIDTH'(narrow(
                            (longint'(act_reg[O]) * longint'(t_reg)) >>> FRAC,
                            WIDTH, SAT_EN));
                        c_reg          <= cn_reg;
                        out_valid_reg  <= 1'b1;
                        outc_phase_reg <= 1'b0;
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        hs_reg        <= y_reg;
                        cs_reg        <= c_reg;
                        out_valid_reg <= 1'b0;
                        x_ready_reg   <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_seq.sv
// Directed testbench for lstm_seq (WIDTH=16, FRAC=8, N_IN=2).
// Expected results are pushed to a scoreboard queue when a vector is sent
// and popped when the cell presents its output.
module tb_lstm_seq;

    localparam int WIDTH  = 16;
    localparam int FRAC   = 8;
    localparam int N_IN   = 2;
    localparam int ADDR_W = 4;

    logic                    clk       = 1'b0;
    logic                    rst_n     = 1'b0;
    logic                    wr_en     = 1'b0;
    logic [ADDR_W-1:0]       wr_addr   = '0;
    logic signed [WIDTH-1:0] wr_data   = '0;
    logic signed [WIDTH-1:0] x_in      = '0;
    logic                    x_valid   = 1'b0;
    logic                    x_last    = 1'b0;
    logic                    seq_start = 1'b0;
    logic                    out_ready = 1'b0;
    logic                    x_ready;
    logic                    out_valid;
    logic                    busy;
    logic signed [WIDTH-1:0] y_out;
    logic signed [WIDTH-1:0] C_out;

    typedef struct {
        logic signed [WIDTH-1:0] y;
        logic signed [WIDTH-1:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    lstm_seq #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .N_IN  (N_IN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .x_in      (x_in),
        .x_valid   (x_valid),
        .x_last    (x_last),
        .seq_start (seq_start),
        .x_ready   (x_ready),
        .y_out     (y_out),
        .C_out     (C_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_w(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = WIDTH'(data);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Biases live at 4*N_IN+4+g = 12+g
    task automatic write_bias(input int bi, input int bf, input int bg, input int bo);
        write_w(12, bi);
        write_w(13, bf);
        write_w(14, bg);
        write_w(15, bo);
    endtask

    task automatic send_beat(input int x, input bit last, input bit seq);
        int n = 0;
        x_in      = WIDTH'(x);
        x_valid   = 1'b1;
        x_last    = last;
        seq_start = seq;
        while (x_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("beat_accept_wait", (n < 200), 1);
        @(negedge clk);
        x_valid   = 1'b0;
        x_last    = 1'b0;
        seq_start = 1'b0;
    endtask

    task automatic send_vec(input string tag, input int x0, input int x1, input bit seq,
                            input bit last, input int y_e, input int c_e);
        exp_t e;
        e.y = WIDTH'(y_e);
        e.c = WIDTH'(c_e);
        exp_q.push_back(e);
        $display("send %s x={%0d,%0d} seq_start=%0d", tag, x0, x1, seq);
        send_beat(x0, 1'b0, seq);
        send_beat(x1, last, 1'b0);
        check({tag, "_xready_low"}, x_ready, 0);
    endtask

    task automatic collect(input string tag, input int hold);
        int   lat = 0;
        int   bad = 0;
        exp_t e;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 5);
        e = exp_q.pop_front();
        check({tag, "_y"}, y_out, e.y);
        check({tag, "_c"}, C_out, e.c);
        $display("recv %s y_out=%0d C_out=%0d latency=%0d", tag, y_out, C_out, lat);
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (out_valid !== 1'b1 || x_ready !== 1'b0 || busy !== 1'b1 ||
                    y_out !== e.y || C_out !== e.c) bad++;
            end
            check({tag, "_hold_stable"}, bad, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_valid"}, out_valid, 0);
        check({tag, "_post_busy"}, busy, 0);
        check({tag, "_post_xready"}, x_ready, 1);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_x_ready", x_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y_out, 0);
        check("rst_c", C_out, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rel_x_ready", x_ready, 1);

        // All weights zero: i=f=o=0.5, g=0 -> C=0, y=0
        for (int a = 0; a < 16; a++) write_w(a, 0);
        send_vec("zero_w", 100, 200, 1'b1, 1'b1, 0, 0);
        collect("zero_w", 0);

        // Bias only: i=1, f=0, g=1, o=1 -> C=1.0, y=1.0
        write_bias(1024, -1024, 256, 1024);
        send_vec("bias", 0, 0, 1'b1, 1'b1, 256, 256);
        collect("bias", 0);

        // Continue sequence with f=0.5: C = 0.5*1 + 1*1 = 1.5, y = tanh'(1.5)=1.0.
        // Second beat omits x_last: the full-vector count must close the step.
        write_w(13, 0);
        send_vec("carry_nolast", 0, 0, 1'b0, 1'b0, 256, 384);
        collect("carry_nolast", 0);

        // Backpressure: fresh sequence, f=0.5 with C=0 -> C=1.0, y=1.0
        send_vec("hold", 0, 0, 1'b1, 1'b1, 256, 256);
        collect("hold", 10);

        // Write to wx[g][0] while accumulating must be dropped
        exp_q.push_back('{y: 16'sd256, c: 16'sd256});
        $display("send accum_wr x={0,0} seq_start=1 with weight write in ACCUM");
        send_beat(0, 1'b0, 1'b1);
        check("accum_wr_busy", busy, 1);
        write_w(4, -512);
        send_beat(0, 1'b1, 1'b0);
        collect("accum_wr", 0);
        // If wx[g][0] had become -2.0, g would be -1.0 and C=-256
        send_vec("accum_wr_readback", 256, 0, 1'b1, 1'b1, 256, 256);
        collect("accum_wr_readback", 0);

        // Reset during ACCUM: step discarded, state cleared, weights kept
        $display("send mid_reset x={0,..} seq_start=0 aborted by reset");
        send_beat(0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_y", y_out, 0);
        check("mid_rst_c", C_out, 0);
        check("mid_rst_xready", x_ready, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_no_output", out_valid, 0);
        // With C cleared: C = 0.5*0 + 1*1 = 1.0 (would be 1.5 if C survived)
        send_vec("after_rst", 0, 0, 1'b0, 1'b1, 256, 256);
        collect("after_rst", 0);

        // Overflowing accumulation: wraps to s_i=512, s_f=-1536, s_g=-256, s_o=512
        for (int a = 0; a < 8; a++) write_w(a, 32767);
        write_w(13, -1024);
`ifdef LSTM_SAT_EN
        send_vec("overflow", 32767, 32767, 1'b1, 1'b1, 256, 256);
`else
        send_vec("overflow", 32767, 32767, 1'b1, 1'b1, -256, -256);
`endif
        collect("overflow", 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
